// File: rtl/uart_line_fifo.sv
// Receive byte FIFO behind the uart receiver with a one-cycle pop port, sticky overflow
// and an optional count of stored end-of-line bytes (enabled by UART_LINE_FIFO_LINES_EN).
module uart_line_fifo #(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 4,
    parameter logic [WIDTH-1:0] EOL   = 8'h0a
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             re,
    input  logic [WIDTH-1:0] data_rx,
    input  logic             rd_en,
    input  logic             clear,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [DEPTH:0]   count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic [DEPTH:0]   lines
);

    localparam int             ENTRIES  = 1 << DEPTH;
    localparam logic [DEPTH:0] CNT_FULL = (DEPTH+1)'(ENTRIES);
    localparam logic [DEPTH:0] CNT_ONE  = (DEPTH+1)'(1);
    localparam logic [DEPTH-1:0] PTR_ONE = DEPTH'(1);

    logic [WIDTH-1:0] mem [ENTRIES];
    logic [DEPTH-1:0] wp, rp;
    logic             pop, push, drop;

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign pop  = rd_en & ~empty;
    assign push = re & (~full | pop);
    assign drop = re & ~push;

    always_ff @(posedge clk) begin
        if (push)
            mem[wp] <= data_rx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            rd_valid <= pop;
            if (pop) begin
                rd_data <= mem[rp];
                rp      <= rp + PTR_ONE;
            end
            if (push)
                wp <= wp + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // A drop in the same cycle as clear leaves the flag set.
            if (drop)
                overflow <= 1'b1;
            else if (clear)
                overflow <= 1'b0;
        end
    end

`ifdef UART_LINE_FIFO_LINES_EN
    logic eol_in, eol_out;

    assign eol_in  = push & (data_rx == EOL);
    assign eol_out = pop & (mem[rp] == EOL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            lines <= '0;
        else if (eol_in & ~eol_out)
            lines <= lines + CNT_ONE;
        else if (eol_out & ~eol_in)
            lines <= lines - CNT_ONE;
    end
`else
    assign lines = '0;
`endif

endmodule

// File: doc/uart_line_fifo.md
# uart_line_fifo

Receive-side byte buffer that sits directly downstream of the `uart` receiver, consuming its `re`/`data_rx` strobe and byte. It stores received bytes in a small circular FIFO and exposes a one-cycle-latency pop port. It also tracks how many complete end-of-line-terminated lines are held, so a consumer (SoC peripheral or bench checker) can drain text a line at a time. It flags dropped bytes with a sticky overflow bit.

## Interface
Parameters:
- `WIDTH`, 8: byte width; must match the upstream `uart` `WIDTH`.
- `DEPTH`, 4: log2 of the entry count (16 entries by default).
- `EOL`, 8'h0a: byte value that terminates a line.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `re`  in  1: write strobe from the `uart` receiver; one pulse per byte.
- `data_rx`  in  WIDTH: received byte; valid when `re`=1.
- `rd_en`  in  1: pop request.
- `clear`  in  1: clears `overflow`.
- `rd_data`  out  WIDTH: popped byte; valid when `rd_valid`=1.
- `rd_valid`  out  1: one-cycle pulse marking `rd_data` valid.
- `count`  out  DEPTH+1: number of stored entries, 0..2^DEPTH.
- `empty`  out  1: `count`==0.
- `full`  out  1: `count`==2^DEPTH.
- `overflow`  out  1: sticky; a byte was dropped.
- `lines`  out  DEPTH+1: number of stored `EOL` bytes.

## Operation
- Storage: 2^DEPTH x WIDTH array, write pointer `wp` and read pointer `rp`, both DEPTH bits wide. Pointers wrap modulo 2^DEPTH without special handling.
- Pop accepted (`pop`) = `rd_en` & ~`empty`. On accept: `rd_data` <= mem[`rp`], `rp`++, `rd_valid` <= 1. Otherwise `rd_valid` <= 0 and `rd_data` holds its last value. `rd_en` while empty is ignored and has no side effects.
- Push accepted (`push`) = `re` & (~`full` | `pop`). When full, a simultaneous pop frees the slot in the same cycle. On accept: mem[`wp`] <= `data_rx`, `wp`++.
- Dropped byte (`re` & ~`push`): `overflow` <= 1. The FIFO contents and pointers are unchanged.
- `count` next value: +1 on push only, -1 on pop only, unchanged on both or neither.
- `lines` next value: +1 if the pushed byte == `EOL`; -1 if the popped byte == `EOL`. When both occur in the same cycle, `lines` is unchanged.
- `clear` sets `overflow` <= 0. If `clear` and a drop happen in the same cycle, the drop wins and `overflow` = 1.
- `empty` and `full` are decoded from registered `count`.
- No state machine beyond the pointer/counter datapath. Reset mid-operation discards all contents immediately.

## Timing
- Reset values: `rd_data`=0, `rd_valid`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0, `lines`=0, `wp`=`rp`=0. Memory contents are not reset.
- Pop latency: `rd_en` sampled at edge N drives `rd_data`/`rd_valid` after edge N. `rd_valid` is high for exactly one cycle per accepted pop.
- Push-to-readable latency: a byte pushed at edge N raises `count`/clears `empty` after N. The earliest pop is at edge N+1, with data valid after N+1.
- Back-to-back pops with `rd_en` held high deliver one byte per cycle until `empty`.
- Throughput is one push and one pop per cycle simultaneously.

## Configuration
- `UART_LINE_FIFO_LINES_EN` defined: the `EOL` compare logic and `lines` counter are built as described.
- Not defined: `lines` is tied to 0, no compare logic is generated, and `EOL` is unused. All other behaviour is identical.

## Test plan
- Reset, then push "OK\n" (8'h4f, 8'h4b, 8'h0a) via 1-cycle `re` pulses -> `count`=3, `lines`=1 (macro on). Then 3 pops give `rd_data` 4f, 4b, 0a with `rd_valid` pulses, and afterwards `count`=0, `empty`=1, `lines`=0.
- Push 16 bytes 0x00..0x0f -> `full`=1. A 17th `re` with 0x55 -> `overflow`=1, `count` stays 16. Draining returns 0x00..0x0f in order with no 0x55.
- With `full`=1, assert `re`=1 (0xaa) and `rd_en`=1 in the same cycle -> pop returns 0x00, 0xaa is stored, `count` stays 16, `overflow` stays 0.
- Push/pop 40 bytes streaming with `count` kept at 1-3 (pointer wrap) -> the output sequence equals the input sequence exactly.
- Assert `clear` -> `overflow`=0. Assert `clear` together with a dropped write -> `overflow`=1. Pulse `rd_en` while empty -> `rd_valid` stays 0 and `count` stays 0.
- Assert `reset` asynchronously mid-stream with `count`=5 -> all outputs return to their reset values before the next clock edge.
